sd_cmd_sequencer: RTL and testbench
===================================

// Module: sd_cmd_sequencer
// PURPOSE
//  Bus master that drives the SD controller's 8-bit register port to run one SD command transaction.
//  - Builds the 6-byte command frame, including CRC7, and writes it to the TX command FIFO (adr 0).
//  - Polls the status register (adr 4) and drains the response bytes from the RX command FIFO (adr 1).
//  - Sits between the Saturn-side command logic and the SD controller. Avoids CPU byte-banging.
// PARAMETERS
//  POLL_LIMIT  16'd50000  max status reads per byte wait before declaring timeout
//  RESP_MAX    17         max response bytes accepted (R2 = 17)
// PORTS
//  wb_clk_i        in   1   system clock; single clock domain
//  wb_rst_i        in   1   asynchronous, active-high reset
//  start_i         in   1   1-cycle pulse; launches a command; ignored while busy_o=1
//  cmd_idx_i       in   6   SD command index, sampled on start_i
//  cmd_arg_i       in   32  SD command argument, sampled on start_i
//  resp_len_i      in   5   response bytes to read (0..RESP_MAX), sampled on start_i
//  busy_o          out  1   high from the cycle after start_i until done_o
//  done_o          out  1   1-cycle pulse; transaction finished (ok or timeout)
//  timeout_o       out  1   valid with done_o; held until next start_i
//  resp_byte_o     out  8   response byte
//  resp_valid_o    out  1   1-cycle pulse per response byte, in order received
//  m_adr_o         out  3   register address to controller
//  m_dat_o         out  8   write data to controller
//  m_dat_i         in   8   read data from controller
//  m_write_n_o     out  1   active-low write strobe
//  m_read_n_o      out  1   active-low read strobe
//  m_chipselect_o  out  1   chip select
//  m_waitrequest_i in   1   high = slave not ready; transfer completes in first cycle it is low
// BEHAVIOUR
//  Reset values:
//  - busy, done, timeout, resp_valid, chipselect = 0
//  - write_n = read_n = 1; adr, dat_o, resp_byte = 0; FSM in IDLE
//  Reset mid-transaction aborts immediately. Strobes release asynchronously. No done_o is issued.
//  Frame construction:
//  - b0 = {2'b01, cmd_idx}; b1..b4 = cmd_arg[31:24]..[7:0]; b5 = {crc7, 1'b1}
//  - CRC7 poly x^7+x^3+1, init 0, computed over b0..b4 MSB first, in LOAD (at most 8 cycles)
//  Bus cycle rules:
//  - chipselect and exactly one strobe asserted, with adr/dat stable, until waitrequest_i=0
//  - read data is captured in that cycle
//  - all strobes deassert for at least 1 cycle between transfers
//  - never read and write simultaneously
//  FSM transitions:
//  - IDLE -> LOAD on start_i: latch inputs, busy_o=1, clear timeout_o, byte count=0
//  - LOAD -> TXST when CRC done
//  - TXST: read adr 4. If bit0 (TX full)=1, re-read and count. Else -> TXWR
//  - TXWR: write frame[n] to adr 0; n++
//      - n<6 -> TXST
//      - n=6, resp_len=0 -> DONE
//      - n=6, resp_len>0 -> RXST
//  - RXST: read adr 4. If bit1 (RX empty)=1, re-read and count. Else -> RXRD
//  - RXRD: read adr 1; resp_byte_o=m_dat_i with resp_valid_o pulse in the cycle after capture
//      - count < resp_len -> RXST
//      - else -> DONE
//  - DONE: done_o=1, busy_o=0 next cycle -> IDLE
//  Poll counter:
//  - cleared on entering TXST/RXST for each byte
//  - reaches POLL_LIMIT -> timeout_o=1 -> DONE; remaining bytes not read
//  resp_len_i > RESP_MAX is clamped to RESP_MAX.
//  start_i coincident with DONE is ignored; the next start is accepted in IDLE only.
//  waitrequest_i stuck high stalls the FSM indefinitely. It is not counted as a poll.
// TESTING
//  1. CMD0, arg 0, resp_len 0 -> writes 40 00 00 00 00 95 to adr 0; done_o, timeout_o=0, no resp_valid
//  2. CMD8, arg 0x1AA, resp_len 6, slave returns 08 00 00 01 AA 13
//     -> frame 48 00 00 01 AA 87; six resp_valid pulses with those bytes in order
//  3. waitrequest held high 5 cycles per access -> strobes/adr/dat stable throughout; frame unchanged
//  4. status bit0=1 for 3 reads before first write -> 3 extra adr-4 reads, then normal frame
//  5. status bit1 stuck 1, POLL_LIMIT=8 -> exactly 8 adr-4 reads after frame, then done_o with timeout_o=1
//  6. wb_rst_i pulsed during RXRD, and start_i while busy
//     -> strobes high/cs low at once, outputs at reset values; start while busy ignored

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - SD command transaction sequencer driving the controller register port
module sd_cmd_sequencer #(
    parameter logic [15:0] POLL_LIMIT = 16'd50000,
    parameter int          RESP_MAX   = 17
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [5:0]  cmd_idx_i,
    input  logic [31:0] cmd_arg_i,
    input  logic [4:0]  resp_len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [7:0]  resp_byte_o,
    output logic        resp_valid_o,
    output logic [2:0]  m_adr_o,
    output logic [7:0]  m_dat_o,
    input  logic [7:0]  m_dat_i,
    output logic        m_write_n_o,
    output logic        m_read_n_o,
    output logic        m_chipselect_o,
    input  logic        m_waitrequest_i
);

    localparam logic [4:0] RESP_MAX_L = 5'(RESP_MAX);
    localparam logic [2:0] ADR_TX     = 3'd0;
    localparam logic [2:0] ADR_RX     = 3'd1;
    localparam logic [2:0] ADR_STATUS = 3'd4;

    typedef enum logic [2:0] {IDLE, LOAD, TXST, TXWR, RXST, RXRD, DONE} state_t;

    state_t      state;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic [4:0]  len_q;
    logic [6:0]  crc_q;
    logic [2:0]  ld_cnt;
    logic [2:0]  tx_cnt;
    logic [4:0]  rx_cnt;
    logic [15:0] poll_cnt;
    logic        acc;        // a bus transfer is currently presented on the port
    logic        poll_last;

    assign poll_last = (poll_cnt == POLL_LIMIT - 16'd1);

    // One byte of CRC7 (x^7 + x^3 + 1), MSB first
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] b);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // Byte n of the 6-byte command frame
    function automatic logic [7:0] frame_at(input logic [2:0] n);
        case (n)
            3'd0:    return {2'b01, idx_q};
            3'd1:    return arg_q[31:24];
            3'd2:    return arg_q[23:16];
            3'd3:    return arg_q[15:8];
            3'd4:    return arg_q[7:0];
            default: return {crc_q, 1'b1};
        endcase
    endfunction

    // Transaction FSM; every bus strobe is registered and dropped for a cycle after each transfer
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            resp_byte_o    <= 8'h00;
            resp_valid_o   <= 1'b0;
            m_adr_o        <= 3'd0;
            m_dat_o        <= 8'h00;
            m_write_n_o    <= 1'b1;
            m_read_n_o     <= 1'b1;
            m_chipselect_o <= 1'b0;
            idx_q          <= 6'd0;
            arg_q          <= 32'd0;
            len_q          <= 5'd0;
            crc_q          <= 7'd0;
            ld_cnt         <= 3'd0;
            tx_cnt         <= 3'd0;
            rx_cnt         <= 5'd0;
            poll_cnt       <= 16'd0;
            acc            <= 1'b0;
        end else begin
            done_o       <= 1'b0;
            resp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        idx_q     <= cmd_idx_i;
                        arg_q     <= cmd_arg_i;
                        len_q     <= (resp_len_i > RESP_MAX_L) ? RESP_MAX_L : resp_len_i;
                        busy_o    <= 1'b1;
                        timeout_o <= 1'b0;
                        crc_q     <= 7'd0;
                        ld_cnt    <= 3'd0;
                        tx_cnt    <= 3'd0;
                        rx_cnt    <= 5'd0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    crc_q <= crc7_byte(crc_q, frame_at(ld_cnt));
                    if (ld_cnt == 3'd4) begin
                        poll_cnt <= 16'd0;
                        state    <= TXST;
                    end else begin
                        ld_cnt <= ld_cnt + 3'd1;
                    end
                end
                TXST, RXST: begin
                    if (!acc) begin
                        acc            <= 1'b1;
                        m_chipselect_o <= 1'b1;
                        m_read_n_o     <= 1'b0;
                        m_adr_o        <= ADR_STATUS;
                    end else if (!m_waitrequest_i) begin
                        acc            <= 1'b0;
                        m_chipselect_o <= 1'b0;
                        m_read_n_o     <= 1'b1;
                        // bit0 = TX full while sending, bit1 = RX empty while receiving
                        if ((state == TXST) ? m_dat_i[0] : m_dat_i[1]) begin
                            if (poll_last) begin
                                timeout_o <= 1'b1;
                                state     <= DONE;
                            end else begin
                                poll_cnt <= poll_cnt + 16'd1;
                            end
                        end else begin
                            state <= (state == TXST) ? TXWR : RXRD;
                        end
                    end
                end
                TXWR: begin
                    if (!acc) begin
                        acc            <= 1'b1;
                        m_chipselect_o <= 1'b1;
                        m_write_n_o    <= 1'b0;
                        m_adr_o        <= ADR_TX;
                        m_dat_o        <= frame_at(tx_cnt);
                    end else if (!m_waitrequest_i) begin
                        acc            <= 1'b0;
                        m_chipselect_o <= 1'b0;
                        m_write_n_o    <= 1'b1;
                        tx_cnt         <= tx_cnt + 3'd1;
                        poll_cnt       <= 16'd0;
                        if (tx_cnt != 3'd5) state <= TXST;
                        else if (len_q == 5'd0) state <= DONE;
                        else state <= RXST;
                    end
                end
                RXRD: begin
                    if (!acc) begin
                        acc            <= 1'b1;
                        m_chipselect_o <= 1'b1;
                        m_read_n_o     <= 1'b0;
                        m_adr_o        <= ADR_RX;
                    end else if (!m_waitrequest_i) begin
                        acc            <= 1'b0;
                        m_chipselect_o <= 1'b0;
                        m_read_n_o     <= 1'b1;
                        resp_byte_o    <= m_dat_i;
                        resp_valid_o   <= 1'b1;
                        rx_cnt         <= rx_cnt + 5'd1;
                        poll_cnt       <= 16'd0;
                        state          <= (rx_cnt + 5'd1 < len_q) ? RXST : DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - directed self-checking bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [5:0]  cmd_idx_i = 6'd0;
    logic [31:0] cmd_arg_i = 32'd0;
    logic [4:0]  resp_len_i = 5'd0;
    logic        busy_o, done_o, timeout_o, resp_valid_o;
    logic [7:0]  resp_byte_o;
    logic [2:0]  m_adr_o;
    logic [7:0]  m_dat_o;
    logic [7:0]  m_dat_i = 8'h00;
    logic        m_write_n_o, m_read_n_o, m_chipselect_o;
    logic        m_waitrequest_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // slave model configuration and observations
    int         wait_cycles = 0;
    int         tx_full_left = 0;
    bit         rx_stuck = 0;
    logic [7:0] rx_q[$];
    logic [7:0] writes[$];
    logic [7:0] got[$];
    int         st_reads = 0;
    int         st_after = 0;
    int         viol = 0;
    int         done_cnt = 0;
    logic       last_to = 1'b0;
    int         wcnt = 0;
    bit         holding = 0;
    bit         compl_prev = 0;
    logic [2:0] h_adr;
    logic [7:0] h_dat;
    logic       h_rd;

    sd_cmd_sequencer #(.POLL_LIMIT(16'd8), .RESP_MAX(17)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i),
        .cmd_idx_i(cmd_idx_i), .cmd_arg_i(cmd_arg_i), .resp_len_i(resp_len_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .resp_byte_o(resp_byte_o), .resp_valid_o(resp_valid_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_write_n_o(m_write_n_o), .m_read_n_o(m_read_n_o),
        .m_chipselect_o(m_chipselect_o), .m_waitrequest_i(m_waitrequest_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pack6(input logic [7:0] q[$]);
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < 6; i++) v = {v[39:0], q[i]};
        return v;
    endfunction

    // Register-port slave: decides waitrequest/read data on the falling edge, so a
    // transfer released here completes at the following rising edge
    always @(negedge wb_clk_i) begin
        logic act;
        act = m_chipselect_o && (!m_read_n_o || !m_write_n_o);
        if (!m_read_n_o && !m_write_n_o) viol++;
        if (act) begin
            if (compl_prev) viol++;
            if (holding && (m_adr_o !== h_adr || m_dat_o !== h_dat || m_read_n_o !== h_rd)) viol++;
            if (wcnt < wait_cycles) begin
                m_waitrequest_i = 1'b1;
                wcnt++;
                holding = 1;
                h_adr = m_adr_o; h_dat = m_dat_o; h_rd = m_read_n_o;
                compl_prev = 0;
            end else begin
                m_waitrequest_i = 1'b0;
                wcnt = 0;
                holding = 0;
                compl_prev = 1;
                if (!m_write_n_o) begin
                    if (m_adr_o == 3'd0) writes.push_back(m_dat_o);
                end else if (m_adr_o == 3'd4) begin
                    m_dat_i = {6'd0, rx_stuck || (rx_q.size() == 0), tx_full_left > 0};
                    if (tx_full_left > 0) tx_full_left--;
                    st_reads++;
                    if (writes.size() >= 6) st_after++;
                end else if (m_adr_o == 3'd1) begin
                    m_dat_i = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
                end
            end
        end else begin
            m_waitrequest_i = 1'b0;
            wcnt = 0;
            holding = 0;
            compl_prev = 0;
        end
    end

    // Output monitor for response bytes and completion
    always @(negedge wb_clk_i) begin
        if (resp_valid_o) got.push_back(resp_byte_o);
        if (done_o) begin
            done_cnt++;
            last_to = timeout_o;
        end
    end

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [4:0] len);
        int base;
        int n;
        writes.delete();
        got.delete();
        st_reads = 0;
        st_after = 0;
        base = done_cnt;
        @(negedge wb_clk_i);
        cmd_idx_i = idx; cmd_arg_i = arg; resp_len_i = len; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check({tag, "_busy"}, busy_o, 1'b1);
        n = 0;
        while (done_cnt == base && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check({tag, "_done_in_time"}, n < 3000, 1'b1);
        @(negedge wb_clk_i);
        check({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        int base;
        int n;
        repeat (3) @(negedge wb_clk_i);
        check("rst_flags", {busy_o, done_o, timeout_o, resp_valid_o, m_chipselect_o}, 5'b0);
        check("rst_strobes", {m_write_n_o, m_read_n_o}, 2'b11);
        check("rst_data", {m_adr_o, m_dat_o, resp_byte_o}, 19'd0);
        wb_rst_i = 1'b0;

        // 1: CMD0, no response
        run_cmd("t1", 6'd0, 32'd0, 5'd0);
        check("t1_nwr", writes.size(), 6);
        check("t1_frame", pack6(writes), 48'h40_00_00_00_00_95);
        check("t1_to", last_to, 1'b0);
        check("t1_nresp", got.size(), 0);
        check("t1_streads", st_reads, 6);

        // 2: CMD8 with R7 response
        rx_q = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        run_cmd("t2", 6'd8, 32'h0000_01AA, 5'd6);
        check("t2_frame", pack6(writes), 48'h48_00_00_01_AA_87);
        check("t2_nresp", got.size(), 6);
        check("t2_resp", pack6(got), 48'h08_00_00_01_AA_13);
        check("t2_streads", st_reads, 12);
        check("t2_to", last_to, 1'b0);

        // 3: five wait states on every access
        wait_cycles = 5;
        viol = 0;
        rx_q = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        run_cmd("t3", 6'd8, 32'h0000_01AA, 5'd6);
        check("t3_frame", pack6(writes), 48'h48_00_00_01_AA_87);
        check("t3_resp", pack6(got), 48'h08_00_00_01_AA_13);
        check("t3_bus_rules", viol, 0);
        wait_cycles = 0;

        // 4: TX FIFO full for three status reads
        tx_full_left = 3;
        run_cmd("t4", 6'd0, 32'd0, 5'd0);
        check("t4_frame", pack6(writes), 48'h40_00_00_00_00_95);
        check("t4_streads", st_reads, 9);

        // 5: RX never non-empty -> timeout after POLL_LIMIT reads
        rx_stuck = 1;
        run_cmd("t5", 6'd8, 32'h0000_01AA, 5'd6);
        check("t5_poll_reads", st_after, 8);
        check("t5_to", last_to, 1'b1);
        check("t5_nresp", got.size(), 0);
        repeat (4) @(negedge wb_clk_i);
        check("t5_to_held", timeout_o, 1'b1);
        rx_stuck = 0;

        // response length above the maximum is clamped
        rx_q.delete();
        for (int i = 1; i <= 20; i++) rx_q.push_back(8'(i));
        run_cmd("clamp", 6'd55, 32'd0, 5'd31);
        check("clamp_frame", pack6(writes), 48'h77_00_00_00_00_65);
        check("clamp_nresp", got.size(), 17);
        check("clamp_last", (got.size() == 17) ? got[16] : 8'h00, 8'h11);
        check("clamp_left", rx_q.size(), 3);
        check("clamp_to_cleared", last_to, 1'b0);

        // 6: start while busy, then reset during a response read
        wait_cycles = 5;
        rx_q = '{8'h08, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h13};
        writes.delete();
        base = done_cnt;
        @(negedge wb_clk_i);
        cmd_idx_i = 6'd8; cmd_arg_i = 32'h0000_01AA; resp_len_i = 5'd6; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        cmd_idx_i = 6'd0; cmd_arg_i = 32'hFFFF_FFFF; start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        n = 0;
        while (!(m_read_n_o == 1'b0 && m_adr_o == 3'd1) && n < 3000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("t6_reached_rxrd", n < 3000, 1'b1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("t6_rst_strobes", {m_write_n_o, m_read_n_o, m_chipselect_o}, 3'b110);
        check("t6_rst_flags", {busy_o, done_o, timeout_o, resp_valid_o}, 4'b0);
        check("t6_frame", pack6(writes), 48'h48_00_00_01_AA_87);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        check("t6_no_done", done_cnt, base);
        wait_cycles = 0;
        rx_q.delete();
        run_cmd("t6_recover", 6'd0, 32'd0, 5'd0);
        check("t6_recover_frame", pack6(writes), 48'h40_00_00_00_00_95);
        check("bus_rules_total", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
